dmem_responder: RTL and testbench

- Responder end of the MEM-stage data-memory interface. The pipeline issues load/store requests; this block services them from a word-addressed array with a fixed, configurable access latency.
- Uses a valid/ready request channel and a one-cycle response pulse. The MEM stage freezes the pipeline on busy while an access is outstanding.
- Replaces the zero-wait data memory when modelling slow memory.

---
 rtl/dmem_responder_pkg.sv | 20 ++
 rtl/dmem_array.sv | 38 +++
 rtl/dmem_responder.sv | 116 +++++++++++
 tb/tb_dmem_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared configuration for the data-memory responder: default widths, FSM
// state encoding and a constant log2 helper for the word-index width.
package dmem_responder_pkg;

    localparam int unsigned WORD_LEN    = 32;
    localparam int unsigned ADDRESS_LEN = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Ceiling log2, used at elaboration time only.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for dmem_responder: synchronous write, registered read data,
// both triggered by one access strobe. squash suppresses a store and zeroes a load.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DATA_W = WORD_LEN,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned IDX_W  = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              access,
    input  logic              write,
    input  logic              squash,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    // Contents are never reset; they start at zero.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (access && write && !squash) begin
            mem[idx] <= wdata;
        end
    end

    // Load data is held until the next load completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (access && !write) begin
            rdata <= squash ? '0 : mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder with fixed access latency and a
// valid/ready request channel. Optional address error checking: DMEM_RESP_ERR_EN.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DATA_W  = WORD_LEN,
    parameter int unsigned ADDR_W  = ADDRESS_LEN,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned IDX_W = clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? clog2(LATENCY) : 1;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              accept_c;
    logic              access_c;
    logic              err_c;

`ifdef DMEM_RESP_ERR_EN
    assign err_c = (req_addr[1:0] != 2'b00) || (req_addr[ADDR_W-1:IDX_W+2] != '0);
`else
    logic unused_addr;
    assign err_c       = 1'b0;
    assign unused_addr = ^{req_addr[ADDR_W-1:IDX_W+2], req_addr[1:0]};
`endif

    assign req_ready = (state_q == IDLE) || (state_q == RESP);
    assign accept_c  = req_valid && req_ready;
    assign busy      = (state_q == WAIT) || accept_c;
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;
    // Reset wins over a commit on the same edge so a dropped store never lands.
    assign access_c  = (state_q == WAIT) && (cnt_q == '0) && !rst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept_c) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    write_d = req_write;
                    idx_d   = req_addr[IDX_W+1:2];
                    wdata_d = req_wdata;
                    err_d   = err_c;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .access (access_c),
        .write  (write_q),
        .squash (err_q),
        .idx    (idx_q),
        .wdata  (wdata_q),
        .rdata  (rsp_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    function automatic logic model_err(input logic [31:0] a);
`ifdef DMEM_RESP_ERR_EN
        return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
`else
        return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
    endfunction

    // Reference: applies one access to the model and returns the expected response.
    task automatic model_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] exp_rd, output logic exp_err);
        int idx;
        idx     = int'((a / 4) % DEPTH);
        exp_err = model_err(a);
        if (w) begin
            if (!exp_err) mem_m[idx] = d;
        end else begin
            last_rd = exp_err ? 32'h0 : mem_m[idx];
        end
        exp_rd = last_rd;
    endtask

    // Drives one request from idle and observes its response.
    task automatic run_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] rd, output logic er,
                           output logic busy_ok, output logic pulse_ok);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        lat     = 0;
        busy_ok = 1'b1;
        while (rsp_valid !== 1'b1 && lat < LATENCY + 8) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk); #1;
        pulse_ok = (rsp_valid === 1'b0) && (busy === 1'b0) && (req_ready === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", rsp_err); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        logic [31:0] exp_rd, rd;
        logic exp_e, er, bok, pok;
        int lat;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_rd = '0;
        seen = 1'b0;
        for (int i = 0; i < LATENCY + 3; i++) begin
            if (rsp_valid === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_no_rsp: got %b expected 0", seen); end
        run_req(1'b0, 32'h20, 32'h0, lat, rd, er, bok, pok);
        model_op(1'b0, 32'h20, 32'h0, exp_rd, exp_e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_mid_load: got %h expected 0", rd); end
        checks++; if (rd !== exp_rd) begin errors++; $display("FAIL reset_mid_model: got %h expected %h", rd, exp_rd); end
    endtask

    task automatic test_store_load();
        logic [31:0] exp_rd, rd;
        logic exp_e, er, bok, pok;
        int lat;
        run_req(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er, bok, pok);
        model_op(1'b1, 32'h10, 32'hDEADBEEF, exp_rd, exp_e);
        checks++; if (lat !== LATENCY) begin errors++; $display("FAIL store_latency: got %0d expected %0d", lat, LATENCY); end
        checks++; if (bok !== 1'b1 || pok !== 1'b1) begin errors++; $display("FAIL store_busy_pulse: got %b%b expected 11", bok, pok); end
        checks++; if (rd !== exp_rd) begin errors++; $display("FAIL store_rdata_held: got %h expected %h", rd, exp_rd); end
        run_req(1'b0, 32'h10, 32'h0, lat, rd, er, bok, pok);
        model_op(1'b0, 32'h10, 32'h0, exp_rd, exp_e);
        checks++; if (lat !== LATENCY) begin errors++; $display("FAIL load_latency: got %0d expected %0d", lat, LATENCY); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata: got %h expected deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_err: got %b expected 0", er); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, d, rd0, rd1, exp_rd0, exp_rd1, dummy;
        logic exp_e, busy_ok;
        int r0, r1;
        a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        d = $urandom;
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        model_op(1'b1, a, d, exp_rd0, exp_e);
        req_write = 1'b0;
        req_wdata = $urandom;
        model_op(1'b0, a, 32'h0, exp_rd1, exp_e);
        r0 = -1; r1 = -1; busy_ok = 1'b1; rd0 = '0; rd1 = '0; dummy = '0;
        for (int c = 1; c <= 3 * (LATENCY + 1); c++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) begin
                if (r0 < 0) begin r0 = c; rd0 = rsp_rdata; end
                else if (r1 < 0) begin r1 = c; rd1 = rsp_rdata; end
            end
            if (r0 >= 0 && c == r0 + 1) req_valid = 1'b0;
            if (r1 < 0 && busy !== 1'b1) busy_ok = 1'b0;
        end
        req_valid = 1'b0;
        checks++; if (r0 !== LATENCY) begin errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", r0, LATENCY); end
        checks++; if (r1 - r0 !== LATENCY + 1) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", r1 - r0, LATENCY + 1); end
        checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy_ok); end
        checks++; if (rd0 !== exp_rd0) begin errors++; $display("FAIL b2b_store_rdata: got %h expected %h", rd0, exp_rd0); end
        checks++; if (rd1 !== exp_rd1) begin errors++; $display("FAIL b2b_load_rdata: got %h expected %h", rd1, exp_rd1); end
    endtask

`ifndef DMEM_RESP_ERR_EN
    task automatic test_wrap();
        logic [31:0] exp_rd, rd;
        logic exp_e, er, bok, pok;
        int lat;
        run_req(1'b1, 32'h404, 32'h5, lat, rd, er, bok, pok);
        model_op(1'b1, 32'h404, 32'h5, exp_rd, exp_e);
        run_req(1'b0, 32'h004, 32'h0, lat, rd, er, bok, pok);
        model_op(1'b0, 32'h004, 32'h0, exp_rd, exp_e);
        checks++; if (rd !== 32'h5) begin errors++; $display("FAIL wrap_load: got %h expected 5", rd); end
        run_req(1'b1, 32'h10, 32'hCAFEF00D, lat, rd, er, bok, pok);
        model_op(1'b1, 32'h10, 32'hCAFEF00D, exp_rd, exp_e);
        run_req(1'b0, 32'h13, 32'h0, lat, rd, er, bok, pok);
        model_op(1'b0, 32'h13, 32'h0, exp_rd, exp_e);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL low_bits_ignored: got %h expected cafef00d", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL wrap_err_tied: got %b expected 0", er); end
    endtask
`else
    task automatic test_err();
        logic [31:0] exp_rd, rd;
        logic exp_e, er, bok, pok;
        int lat;
        run_req(1'b1, 32'h20, 32'h600DF00D, lat, rd, er, bok, pok);
        model_op(1'b1, 32'h20, 32'h600DF00D, exp_rd, exp_e);
        run_req(1'b1, 32'h22, 32'hBAD0BAD0, lat, rd, er, bok, pok);
        model_op(1'b1, 32'h22, 32'hBAD0BAD0, exp_rd, exp_e);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_store_flag: got %b expected 1", er); end
        checks++; if (lat !== LATENCY) begin errors++; $display("FAIL err_store_latency: got %0d expected %0d", lat, LATENCY); end
        run_req(1'b0, 32'h20, 32'h0, lat, rd, er, bok, pok);
        model_op(1'b0, 32'h20, 32'h0, exp_rd, exp_e);
        checks++; if (rd !== 32'h600DF00D) begin errors++; $display("FAIL err_store_suppressed: got %h expected 600df00d", rd); end
        run_req(1'b0, 32'h400, 32'h0, lat, rd, er, bok, pok);
        model_op(1'b0, 32'h400, 32'h0, exp_rd, exp_e);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_load_flag: got %b expected 1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_load_rdata: got %h expected 0", rd); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] a, d, exp_rd, rd;
        logic w, exp_e, er, bok, pok;
        int lat;
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) a = a + 32'(DEPTH * 4) * 32'($urandom_range(1, 3));
            d = $urandom;
            run_req(w, a, d, lat, rd, er, bok, pok);
            model_op(w, a, d, exp_rd, exp_e);
            checks++; if (lat !== LATENCY) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, LATENCY); end
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand_rdata[%0d] addr %h: got %h expected %h", i, a, rd, exp_rd); end
            checks++; if (er !== exp_e) begin errors++; $display("FAIL rand_err[%0d] addr %h: got %b expected %b", i, a, er, exp_e); end
            checks++; if (bok !== 1'b1 || pok !== 1'b1) begin errors++; $display("FAIL rand_busy_pulse[%0d]: got %b%b expected 11", i, bok, pok); end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        test_reset();
        test_reset_mid();
        test_store_load();
        test_back_to_back();
`ifndef DMEM_RESP_ERR_EN
        test_wrap();
`else
        test_err();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
